cla_pipe_adder: RTL and testbench



---
 rtl/cla_pkg.sv | 32 +++
 rtl/cla_group.sv | 55 +++++
 rtl/cla_pipe_adder.sv | 113 +++++++++++
 tb/tb_cla_pipe_adder.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder: stage count,
// the per-stage pipeline record and the parameter legality check.
package cla_pkg;

   // Widest operand the stage record can carry; narrower adders use the low bits.
   localparam int MAXW = 64;

   // Number of pipeline stages: one register stage per lookahead group.
   function automatic int cla_nstg(input int width, input int group);
      return width / group;
   endfunction

   // WIDTH must be 4..64 and a whole number of groups; GROUP must be 1..8.
   function automatic bit cla_params_ok(input int width, input int group);
      return (group >= 1) && (group <= 8) && (width >= 4) && (width <= MAXW)
             && ((width % group) == 0);
   endfunction

   // One beat in flight: finished low sum bits, carry into the next group,
   // the raw operands still waiting for their group, the mode flag, and the
   // overflow flag produced by the group that was just processed.
   typedef struct packed {
      logic            valid;
      logic            sub;
      logic            carry;
      logic            ovf;
      logic [MAXW-1:0] sum;
      logic [MAXW-1:0] a;
      logic [MAXW-1:0] b;
   } cla_stage_t;

endpackage

// File: rtl/cla_group.sv
// GROUP-bit combinational carry-lookahead block. Every internal carry is a
// flat sum of products of generate/propagate terms and the group carry-in.
module cla_group
   import cla_pkg::*;
#(
   parameter int GROUP = 4
) (
   input  logic [GROUP-1:0] a,
   input  logic [GROUP-1:0] b,
   input  logic             cin,
   output logic [GROUP-1:0] sum,
   output logic             grp_p,
   output logic             grp_g,
   output logic             cout,
   output logic             ctop
);

   logic [GROUP-1:0] p;
   logic [GROUP-1:0] g;
   logic [GROUP:0]   c;
   logic             gg;

   assign p = a ^ b;
   assign g = a & b;

   // Expand each carry c[i] = g[i-1] | p[i-1]g[i-2] | ... | p[i-1..0]cin.
   always_comb begin
      logic prod;
      logic acc;
      c    = '0;
      c[0] = cin;
      gg   = 1'b0;
      prod = 1'b1;
      acc  = 1'b0;
      for (int i = 1; i <= GROUP; i++) begin
         prod = 1'b1;
         acc  = 1'b0;
         for (int j = i - 1; j >= 0; j--) begin
            acc  = acc | (prod & g[j]);
            prod = prod & p[j];
         end
         c[i] = acc | (prod & cin);
         if (i == GROUP) begin
            gg = acc;
         end
      end
   end

   assign sum   = p ^ c[GROUP-1:0];
   assign grp_p = &p;
   assign grp_g = gg;
   assign cout  = c[GROUP];
   assign ctop  = c[GROUP-1];

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined WIDTH-bit carry-lookahead adder/subtractor. Each stage resolves
// one GROUP-bit slice using the carry registered by the stage before it; the
// finished low bits ride along with the beat so the result leaves aligned.
// A single global stall freezes every stage while the consumer holds off.
module cla_pipe_adder
   import cla_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int GROUP = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_sub,
   input  logic             in_cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_ovf
);

   localparam int NSTG = cla_nstg(WIDTH, GROUP);

   if (!cla_params_ok(WIDTH, GROUP)) begin : g_bad_params
      $error("cla_pipe_adder: WIDTH must be 4..64 and a multiple of GROUP (1..8)");
   end

   cla_stage_t stg_q [NSTG];
   cla_stage_t stg_d [NSTG];
   logic       stall;

   assign stall    = stg_q[NSTG-1].valid && !out_ready;
   assign in_ready = !stall;

   for (genvar k = 0; k < NSTG; k++) begin : g_stage
      cla_stage_t       src;
      cla_stage_t       nxt;
      logic [GROUP-1:0] grp_a;
      logic [GROUP-1:0] grp_b;
      logic [GROUP-1:0] grp_sum;
      logic             grp_p;
      logic             grp_g;
      logic             grp_cout;
      logic             grp_ctop;

      if (k == 0) begin : g_head
         // Stage 0 takes its beat straight from the input port; subtract forces carry-in 1.
         always_comb begin
            src       = '0;
            src.valid = in_valid;
            src.sub   = in_sub;
            src.carry = in_sub | in_cin;
            src.a     = MAXW'(in_a);
            src.b     = MAXW'(in_b);
         end
      end else begin : g_body
         assign src = stg_q[k-1];
      end

      assign grp_a = src.a[k*GROUP +: GROUP];
      assign grp_b = src.sub ? ~src.b[k*GROUP +: GROUP] : src.b[k*GROUP +: GROUP];

      cla_group #(
         .GROUP (GROUP)
      ) u_group (
         .a     (grp_a),
         .b     (grp_b),
         .cin   (src.carry),
         .sum   (grp_sum),
         .grp_p (grp_p),
         .grp_g (grp_g),
         .cout  (grp_cout),
         .ctop  (grp_ctop)
      );

      // Merge this group's sum into the beat and form the carry for the next group.
      always_comb begin
         nxt                        = src;
         nxt.sum[k*GROUP +: GROUP]  = grp_sum;
         nxt.carry                  = grp_g | (grp_p & src.carry);
         nxt.ovf                    = grp_ctop ^ grp_cout;
      end

      assign stg_d[k] = nxt;
   end

   // Advance all stages together unless stalled; bubbles clear valid but keep data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NSTG; k++) begin
            stg_q[k] <= '0;
         end
      end else if (!stall) begin
         for (int k = 0; k < NSTG; k++) begin
            if (stg_d[k].valid) begin
               stg_q[k] <= stg_d[k];
            end else begin
               stg_q[k].valid <= 1'b0;
            end
         end
      end
   end

   assign out_valid = stg_q[NSTG-1].valid;
   assign out_sum   = stg_q[NSTG-1].sum[WIDTH-1:0];
   assign out_cout  = stg_q[NSTG-1].carry;
   assign out_ovf   = stg_q[NSTG-1].ovf;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Testbench for cla_pipe_adder: three instances (16/4, 32/8, 8/8) share one
// stimulus bus; each test selects which instance it observes.
module tb_cla_pipe_adder;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        out_ready;
   logic        in_sub;
   logic        in_cin;
   logic [63:0] a_bus;
   logic [63:0] b_bus;

   logic        r16, v16, c16, o16;
   logic [15:0] s16;
   logic        r32, v32, c32, o32;
   logic [31:0] s32;
   logic        r8, v8, c8, o8;
   logic [7:0]  s8;

   int          sel;
   logic        v_ready, v_valid, v_cout, v_ovf;
   logic [63:0] v_sum;

   int          checks = 0;
   int          errors = 0;

   cla_pipe_adder u_dut16 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r16),
      .in_a(a_bus[15:0]), .in_b(b_bus[15:0]), .in_sub(in_sub), .in_cin(in_cin),
      .out_valid(v16), .out_ready(out_ready), .out_sum(s16), .out_cout(c16), .out_ovf(o16)
   );

   cla_pipe_adder #(.WIDTH(32), .GROUP(8)) u_dut32 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r32),
      .in_a(a_bus[31:0]), .in_b(b_bus[31:0]), .in_sub(in_sub), .in_cin(in_cin),
      .out_valid(v32), .out_ready(out_ready), .out_sum(s32), .out_cout(c32), .out_ovf(o32)
   );

   cla_pipe_adder #(.WIDTH(8), .GROUP(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r8),
      .in_a(a_bus[7:0]), .in_b(b_bus[7:0]), .in_sub(in_sub), .in_cin(in_cin),
      .out_valid(v8), .out_ready(out_ready), .out_sum(s8), .out_cout(c8), .out_ovf(o8)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Route the observed instance onto one set of view signals.
   always_comb begin
      v_ready = r16;
      v_valid = v16;
      v_sum   = 64'(s16);
      v_cout  = c16;
      v_ovf   = o16;
      case (sel)
         1: begin
            v_ready = r32; v_valid = v32; v_sum = 64'(s32); v_cout = c32; v_ovf = o32;
         end
         2: begin
            v_ready = r8; v_valid = v8; v_sum = 64'(s8); v_cout = c8; v_ovf = o8;
         end
         default: ;
      endcase
   end

   // Reference: plain wide addition, returns {ovf, cout, sum}.
   function automatic logic [65:0] model(input int w, input logic [63:0] a, input logic [63:0] b,
                                         input logic sub, input logic cin);
      logic [63:0] m, am, bm, s;
      logic [64:0] full;
      logic        c, ov;
      m    = (64'd1 << w) - 64'd1;
      am   = a & m;
      bm   = (sub ? ~b : b) & m;
      full = {1'b0, am} + {1'b0, bm} + 65'(sub ? 1'b1 : cin);
      c    = full[w];
      s    = full[63:0] & m;
      ov   = (am[w-1] == bm[w-1]) && (s[w-1] != am[w-1]);
      return {ov, c, s};
   endfunction

   task automatic do_reset();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      rst_n     = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic run_directed(input int s, input string name, input logic [63:0] a,
                               input logic [63:0] b, input logic sub, input logic cin,
                               input logic [63:0] esum, input logic ecout, input logic eovf,
                               input int elat);
      int lat;
      sel = s; a_bus = a; b_bus = b; in_sub = sub; in_cin = cin;
      in_valid = 1'b1; out_ready = 1'b1;
      #1;
      checks++;
      if (v_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL %s in_ready: got %b expected 1", name, v_ready);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat = 1;
      while (v_valid !== 1'b1 && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      checks++;
      if (lat != elat) begin
         errors++;
         $display("[TB] FAIL %s latency: got %0d expected %0d", name, lat, elat);
      end
      checks++;
      if (v_sum !== esum) begin
         errors++;
         $display("[TB] FAIL %s sum: got %h expected %h", name, v_sum, esum);
      end
      checks++;
      if (v_cout !== ecout) begin
         errors++;
         $display("[TB] FAIL %s cout: got %b expected %b", name, v_cout, ecout);
      end
      checks++;
      if (v_ovf !== eovf) begin
         errors++;
         $display("[TB] FAIL %s ovf: got %b expected %b", name, v_ovf, eovf);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic run_stream(input int s, input int nbeats, input bit rand_ready, input string name);
      logic [65:0] exp_q[$];
      logic [65:0] e;
      int          w, sent, got, cyc, first, last, extra, nlat;
      bit          prev_stall;
      logic [63:0] prev_sum;
      logic        prev_cout, prev_ovf;
      sel  = s;
      w    = (s == 1) ? 32 : (s == 2) ? 8 : 16;
      nlat = (s == 2) ? 1 : 4;
      sent = 0; got = 0; cyc = 0; first = -1; last = -1;
      prev_stall = 1'b0; prev_sum = '0; prev_cout = 1'b0; prev_ovf = 1'b0;
      while (got < nbeats && cyc < nbeats * 10 + 50) begin
         out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         if (sent < nbeats) begin
            a_bus    = {$urandom(), $urandom()};
            b_bus    = {$urandom(), $urandom()};
            in_sub   = 1'($urandom_range(0, 1));
            in_cin   = 1'($urandom_range(0, 1));
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         #1;
         checks++;
         if (v_ready !== !(v_valid && !out_ready)) begin
            errors++;
            $display("[TB] FAIL %s in_ready cyc %0d: got %b expected %b", name, cyc, v_ready,
                     !(v_valid && !out_ready));
         end
         if (prev_stall) begin
            checks++;
            if (v_valid !== 1'b1 || v_sum !== prev_sum || v_cout !== prev_cout || v_ovf !== prev_ovf) begin
               errors++;
               $display("[TB] FAIL %s hold cyc %0d: got v%b %h c%b o%b expected v1 %h c%b o%b", name, cyc,
                        v_valid, v_sum, v_cout, v_ovf, prev_sum, prev_cout, prev_ovf);
            end
         end
         if (v_valid === 1'b1 && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("[TB] FAIL %s extra beat: got %h expected none", name, v_sum);
            end else begin
               e = exp_q.pop_front();
               if ({v_ovf, v_cout, v_sum} !== e) begin
                  errors++;
                  $display("[TB] FAIL %s beat %0d: got o%b c%b %h expected o%b c%b %h", name, got,
                           v_ovf, v_cout, v_sum, e[65], e[64], e[63:0]);
               end
            end
            if (first < 0) first = cyc;
            last = cyc;
            got++;
         end
         if (in_valid && v_ready) begin
            exp_q.push_back(model(w, a_bus, b_bus, in_sub, in_cin));
            sent++;
         end
         prev_stall = v_valid && !out_ready;
         prev_sum   = v_sum;
         prev_cout  = v_cout;
         prev_ovf   = v_ovf;
         @(posedge clk);
         #1;
         cyc++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      checks++;
      if (got != nbeats) begin
         errors++;
         $display("[TB] FAIL %s count: got %0d expected %0d", name, got, nbeats);
      end
      if (!rand_ready) begin
         checks++;
         if (last - first != nbeats - 1) begin
            errors++;
            $display("[TB] FAIL %s rate: got span %0d expected %0d", name, last - first, nbeats - 1);
         end
      end
      extra = 0;
      repeat (nlat + 3) begin
         if (v_valid === 1'b1) extra++;
         @(posedge clk);
         #1;
      end
      checks++;
      if (extra != 0) begin
         errors++;
         $display("[TB] FAIL %s trailing beats: got %0d expected 0", name, extra);
      end
   endtask

   task automatic test_reset();
      in_valid = 1'b0; out_ready = 1'b1; in_sub = 1'b0; in_cin = 1'b0;
      a_bus = '0; b_bus = '0; sel = 0;
      rst_n = 1'b0;
      #3;
      checks++;
      if ({v16, s16, c16, o16} !== 19'd0) begin
         errors++;
         $display("[TB] FAIL reset16 outputs: got %h expected 0", {v16, s16, c16, o16});
      end
      checks++;
      if ({v32, s32, c32, o32} !== 35'd0) begin
         errors++;
         $display("[TB] FAIL reset32 outputs: got %h expected 0", {v32, s32, c32, o32});
      end
      checks++;
      if ({v8, s8, c8, o8} !== 11'd0) begin
         errors++;
         $display("[TB] FAIL reset8 outputs: got %h expected 0", {v8, s8, c8, o8});
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (r16 !== 1'b1 || v16 !== 1'b0) begin
         errors++;
         $display("[TB] FAIL post-reset ready/valid: got %b%b expected 10", r16, v16);
      end
   endtask

   task automatic test_add();
      run_directed(0, "add_ffff_1",  64'hFFFF, 64'h0001, 1'b0, 1'b0, 64'h0000, 1'b1, 1'b0, 4);
      run_directed(0, "add_7fff_1",  64'h7FFF, 64'h0001, 1'b0, 1'b0, 64'h8000, 1'b0, 1'b1, 4);
      run_directed(0, "add_1234_ci", 64'h1234, 64'h0000, 1'b0, 1'b1, 64'h1235, 1'b0, 1'b0, 4);
   endtask

   task automatic test_sub();
      run_directed(0, "sub_5_7",    64'h0005, 64'h0007, 1'b1, 1'b0, 64'hFFFE, 1'b0, 1'b0, 4);
      run_directed(0, "sub_8000_1", 64'h8000, 64'h0001, 1'b1, 1'b1, 64'h7FFF, 1'b1, 1'b1, 4);
   endtask

   task automatic test_back_to_back();
      do_reset();
      run_stream(0, 100, 1'b0, "stream16");
   endtask

   task automatic test_backpressure();
      do_reset();
      run_stream(0, 100, 1'b1, "stall16");
   endtask

   task automatic test_midstream_reset();
      int stale;
      do_reset();
      sel = 0; out_ready = 1'b0; in_sub = 1'b0; in_cin = 1'b0;
      a_bus = 64'h1111; b_bus = 64'h2222; in_valid = 1'b1;
      repeat (4) begin
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      checks++;
      if (v_valid !== 1'b1 || v_sum !== 64'h3333) begin
         errors++;
         $display("[TB] FAIL midreset full pipe: got v%b %h expected v1 3333", v_valid, v_sum);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({v_valid, v_sum, v_cout, v_ovf} !== 67'd0) begin
         errors++;
         $display("[TB] FAIL midreset async clear: got v%b %h c%b o%b expected all 0",
                  v_valid, v_sum, v_cout, v_ovf);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      stale = 0;
      repeat (10) begin
         @(posedge clk);
         #1;
         if (v_valid !== 1'b0) stale++;
      end
      checks++;
      if (stale != 0) begin
         errors++;
         $display("[TB] FAIL midreset stale beats: got %0d expected 0", stale);
      end
   endtask

   task automatic test_wide();
      do_reset();
      run_directed(1, "w32_carry", 64'hFFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 4);
      run_stream(1, 100, 1'b0, "stream32");
      run_stream(1, 100, 1'b1, "stall32");
   endtask

   task automatic test_narrow();
      do_reset();
      run_directed(2, "w8_ovf", 64'h7F, 64'h01, 1'b0, 1'b0, 64'h80, 1'b0, 1'b1, 1);
      run_stream(2, 100, 1'b0, "stream8");
      run_stream(2, 100, 1'b1, "stall8");
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub();
      test_back_to_back();
      test_backpressure();
      test_midstream_reset();
      test_wide();
      test_narrow();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
